// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and flow-control block for the five-stage core. Keeps a shadow copy
// of the E/M/W hazard state and produces per-stage stall/flush, operand
// forward selects and the data-memory request. A data-memory wait state
// (valid/ready) freezes the whole pipe; an optional wait-timeout flag is
// raised when a single access waits MEM_TIMEOUT cycles.
//
// Optional feature macro: PIPELINE_PERF_CNT_EN
//   When defined, adds CNT_W-bit performance counters perf_cycles,
//   perf_retired, perf_stall and perf_flush as extra output ports.
//
// There is no FSM here: the only sequential state is the shadow pipeline,
// the wait counter and the sticky timeout flag.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W  = 5,
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dec_valid,
   input  logic [REG_ADDR_W-1:0] dec_rs1,
   input  logic [REG_ADDR_W-1:0] dec_rs2,
   input  logic                  dec_use_rs1,
   input  logic                  dec_use_rs2,
   input  logic [REG_ADDR_W-1:0] dec_rd,
   input  logic                  dec_reg_write,
   input  logic                  dec_is_load,
   input  logic                  dec_is_mem,
   input  logic [REG_ADDR_W-1:0] ex_rs1,
   input  logic [REG_ADDR_W-1:0] ex_rs2,
   input  logic                  ex_pc_src,
   input  logic                  mem_ready,
   output logic                  fetch_stall,
   output logic                  decode_stall,
   output logic                  execute_stall,
   output logic                  memory_stall,
   output logic                  writeback_stall,
   output logic                  decode_flush,
   output logic                  execute_flush,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b,
   output logic                  mem_req,
   output logic                  mem_timeout
`ifdef PIPELINE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      perf_cycles,
   output logic [CNT_W-1:0]      perf_retired,
   output logic [CNT_W-1:0]      perf_stall,
   output logic [CNT_W-1:0]      perf_flush
`endif
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  is_load;
      logic                  is_mem;
   } stage_t;

   // Counter wide enough to hold MEM_TIMEOUT so saturation never hides it.
   localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam bit TO_EN = (MEM_TIMEOUT != 0);
   localparam logic [WC_W-1:0] TO_M1 = WC_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   stage_t e_q, m_q, w_q, e_d;
   logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
   logic tmo_q, tmo_d;

   logic mem_wait, redirect, load_use, tmo_hit;

   // Priority select: a non-load in M beats whatever is in W; x0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                          input stage_t m, input stage_t w);
      logic [1:0] sel;
      sel = 2'b00;
      if (m.valid && m.reg_write && !m.is_load && (m.rd != '0) && (m.rd == src))
         sel = 2'b10;
      else if (w.valid && w.reg_write && (w.rd != '0) && (w.rd == src))
         sel = 2'b01;
      return sel;
   endfunction

   // Hazard conditions derived from shadow state and the current inputs.
   always_comb begin
      mem_wait = m_q.valid & m_q.is_mem & ~mem_ready;
      redirect = ex_pc_src & e_q.valid & ~mem_wait;
      load_use = e_q.valid & e_q.is_load & (e_q.rd != '0) & dec_valid &
                 ((dec_use_rs1 & (dec_rs1 == e_q.rd)) |
                  (dec_use_rs2 & (dec_rs2 == e_q.rd)));
      // Timeout reported in the cycle the counter would reach MEM_TIMEOUT.
      tmo_hit  = TO_EN & mem_wait & (wait_cnt_q >= TO_M1);
   end

   // Stall/flush/forward/request outputs; memory wait beats redirect beats load-use.
   always_comb begin
      fetch_stall     = 1'b0;
      decode_stall    = 1'b0;
      execute_stall   = 1'b0;
      memory_stall    = 1'b0;
      writeback_stall = 1'b0;
      decode_flush    = 1'b0;
      execute_flush   = 1'b0;
      forward_a       = fwd_sel(ex_rs1, m_q, w_q);
      forward_b       = fwd_sel(ex_rs2, m_q, w_q);
      mem_req         = m_q.valid & m_q.is_mem;
      mem_timeout     = tmo_q | tmo_hit;
      if (mem_wait) begin
         // Writeback also holds; rewriting the same regfile value is harmless.
         fetch_stall     = 1'b1;
         decode_stall    = 1'b1;
         execute_stall   = 1'b1;
         memory_stall    = 1'b1;
         writeback_stall = 1'b1;
      end else if (redirect) begin
         decode_flush  = 1'b1;
         execute_flush = 1'b1;
      end else if (load_use) begin
         fetch_stall   = 1'b1;
         decode_stall  = 1'b1;
         execute_flush = 1'b1;
      end
   end

   // Next E entry and wait-counter/timeout next state.
   always_comb begin
      e_d = '0;
      if (!execute_flush) begin
         e_d.valid     = dec_valid;
         e_d.rd        = dec_rd;
         e_d.reg_write = dec_reg_write;
         e_d.is_load   = dec_is_load;
         e_d.is_mem    = dec_is_mem;
      end
      wait_cnt_d = '0;
      if (mem_wait)
         wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + WC_W'(1);
      tmo_d = tmo_q | tmo_hit;
   end

   // Shadow pipeline advances together unless memory is waiting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else if (!mem_wait) begin
         e_q <= e_d;
         m_q <= e_q;
         w_q <= m_q;
      end
   end

   // Consecutive wait-cycle counter and sticky timeout flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt_q <= '0;
         tmo_q      <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         tmo_q      <= tmo_d;
      end
   end

`ifdef PIPELINE_PERF_CNT_EN
   logic [CNT_W-1:0] perf_cycles_q, perf_retired_q, perf_stall_q, perf_flush_q;

   // Free-running performance counters, wrapping naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_cycles_q  <= '0;
         perf_retired_q <= '0;
         perf_stall_q   <= '0;
         perf_flush_q   <= '0;
      end else begin
         perf_cycles_q <= perf_cycles_q + CNT_W'(1);
         if (w_q.valid && !writeback_stall)
            perf_retired_q <= perf_retired_q + CNT_W'(1);
         if (fetch_stall)
            perf_stall_q <= perf_stall_q + CNT_W'(1);
         if (execute_flush)
            perf_flush_q <= perf_flush_q + CNT_W'(1);
      end
   end

   assign perf_cycles  = perf_cycles_q;
   assign perf_retired = perf_retired_q;
   assign perf_stall   = perf_stall_q;
   assign perf_flush   = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl built with MEM_TIMEOUT=4.
// Outputs are packed as {5 stalls, decode_flush, execute_flush,
// forward_a, forward_b, mem_req, mem_timeout} and compared one cycle
// step at a time against hand-derived vectors.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       dec_valid;
   logic [4:0] dec_rs1, dec_rs2, dec_rd;
   logic       dec_use_rs1, dec_use_rs2;
   logic       dec_reg_write, dec_is_load, dec_is_mem;
   logic [4:0] ex_rs1, ex_rs2;
   logic       ex_pc_src;
   logic       mem_ready;
   logic       fetch_stall, decode_stall, execute_stall, memory_stall, writeback_stall;
   logic       decode_flush, execute_flush;
   logic [1:0] forward_a, forward_b;
   logic       mem_req, mem_timeout;

   int n_chk  = 0;
   int n_fail = 0;

   logic [12:0] obs;
   assign obs = {fetch_stall, decode_stall, execute_stall, memory_stall, writeback_stall,
                 decode_flush, execute_flush, forward_a, forward_b, mem_req, mem_timeout};

   pipeline_hazard_ctrl #(
      .REG_ADDR_W (5),
      .MEM_TIMEOUT(4),
      .CNT_W      (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .dec_valid      (dec_valid),
      .dec_rs1        (dec_rs1),
      .dec_rs2        (dec_rs2),
      .dec_use_rs1    (dec_use_rs1),
      .dec_use_rs2    (dec_use_rs2),
      .dec_rd         (dec_rd),
      .dec_reg_write  (dec_reg_write),
      .dec_is_load    (dec_is_load),
      .dec_is_mem     (dec_is_mem),
      .ex_rs1         (ex_rs1),
      .ex_rs2         (ex_rs2),
      .ex_pc_src      (ex_pc_src),
      .mem_ready      (mem_ready),
      .fetch_stall    (fetch_stall),
      .decode_stall   (decode_stall),
      .execute_stall  (execute_stall),
      .memory_stall   (memory_stall),
      .writeback_stall(writeback_stall),
      .decode_flush   (decode_flush),
      .execute_flush  (execute_flush),
      .forward_a      (forward_a),
      .forward_b      (forward_b),
      .mem_req        (mem_req),
      .mem_timeout    (mem_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] ev(input logic [4:0] st, input logic df, input logic ef,
                                      input logic [1:0] fa, input logic [1:0] fb,
                                      input logic rq, input logic to);
      return {st, df, ef, fa, fb, rq, to};
   endfunction

   task automatic chk(input string tag, input logic [12:0] exp);
      #1;
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic ld, input logic mem);
      dec_valid     = v;
      dec_rs1       = rs1;
      dec_rs2       = rs2;
      dec_use_rs1   = u1;
      dec_use_rs2   = u2;
      dec_rd        = rd;
      dec_reg_write = rw;
      dec_is_load   = ld;
      dec_is_mem    = mem;
   endtask

   initial begin
      rst = 1'b0;
      dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
      ex_rs1 = 0; ex_rs2 = 0; ex_pc_src = 0; mem_ready = 1;
      #2;
      chk("reset", '0);
      #9;
      rst = 1'b1;

      // forwarding: two writers of x5 flow through M and W
      dec(1, 0, 0, 0, 0, 5, 1, 0, 0);
      chk("idle_dec", '0);
      tick();                              // E=add5a
      tick();                              // E=add5b M=add5a
      dec_valid = 0; ex_rs1 = 5; ex_rs2 = 0;
      chk("fwd_m", ev(5'b00000, 0, 0, 2'b10, 2'b00, 0, 0));
      tick();                              // M=add5b W=add5a
      chk("fwd_m_over_w", ev(5'b00000, 0, 0, 2'b10, 2'b00, 0, 0));
      ex_rs2 = 5;
      chk("fwd_b_m", ev(5'b00000, 0, 0, 2'b10, 2'b10, 0, 0));
      ex_rs2 = 0;
      tick();                              // M=bubble W=add5b
      chk("fwd_w", ev(5'b00000, 0, 0, 2'b01, 2'b00, 0, 0));

      // load-use: lw x3 in E, add x4,x3,x1 in decode
      dec(1, 1, 0, 1, 0, 3, 1, 1, 1);
      ex_rs1 = 0;
      chk("lw_dec", '0);
      tick();                              // E=lw3
      dec(1, 3, 1, 1, 1, 4, 1, 0, 0);
      chk("load_use", ev(5'b11000, 0, 1, 2'b00, 2'b00, 0, 0));
      tick();                              // E=bubble M=lw3
      ex_rs1 = 3;
      chk("lu_bubble_no_load_fwd", ev(5'b00000, 0, 0, 2'b00, 2'b00, 1, 0));
      tick();                              // E=add4 W=lw3
      ex_rs1 = 3; ex_rs2 = 1;
      // redirect setup: another lw x3 enters decode
      dec(1, 1, 0, 1, 0, 3, 1, 1, 1);
      chk("lu_fwd_w", ev(5'b00000, 0, 0, 2'b01, 2'b00, 0, 0));
      tick();                              // E=lw3 M=add4
      dec(1, 3, 0, 1, 0, 4, 1, 0, 0);
      ex_pc_src = 1; ex_rs1 = 0; ex_rs2 = 0;
      chk("redirect_beats_lu", ev(5'b00000, 1, 1, 2'b00, 2'b00, 0, 0));
      ex_pc_src = 0;
      chk("load_use_rs1", ev(5'b11000, 0, 1, 2'b00, 2'b00, 0, 0));
      dec_use_rs1 = 0;
      chk("no_use_no_stall", '0);
      tick();                              // E=add4b M=lw3 W=add4
      dec(1, 2, 6, 1, 1, 0, 0, 0, 1);
      chk("sw_dec", ev(5'b00000, 0, 0, 2'b00, 2'b00, 1, 0));
      tick();                              // E=sw M=add4b W=lw3
      dec(1, 0, 0, 0, 0, 7, 1, 0, 0);
      tick();                              // E=add7 M=sw W=add4b

      // memory wait: 3 cycles of mem_ready low
      dec_valid = 0; mem_ready = 0; ex_rs1 = 4; ex_rs2 = 0;
      chk("wait1", ev(5'b11111, 0, 0, 2'b01, 2'b00, 1, 0));
      tick();
      ex_pc_src = 1;
      chk("wait2_redirect_deferred", ev(5'b11111, 0, 0, 2'b01, 2'b00, 1, 0));
      ex_pc_src = 0;
      tick();
      chk("wait3", ev(5'b11111, 0, 0, 2'b01, 2'b00, 1, 0));
      tick();
      mem_ready = 1;
      chk("wait_ready", ev(5'b00000, 0, 0, 2'b01, 2'b00, 1, 0));
      tick();                              // M=add7 W=sw
      ex_rs1 = 7;
      chk("advance_m", ev(5'b00000, 0, 0, 2'b10, 2'b00, 0, 0));
      ex_rs1 = 4;
      chk("advance_w_store", '0);

      // timeout: lw x9 waits 6 cycles, MEM_TIMEOUT=4
      dec(1, 0, 0, 0, 0, 9, 1, 1, 1);
      ex_rs1 = 0;
      tick();                              // E=lw9
      dec_valid = 0;
      tick();                              // M=lw9
      mem_ready = 0;
      chk("to_w1", ev(5'b11111, 0, 0, 2'b00, 2'b00, 1, 0));
      tick();
      tick();
      chk("to_w3", ev(5'b11111, 0, 0, 2'b00, 2'b00, 1, 0));
      tick();
      chk("to_w4", ev(5'b11111, 0, 0, 2'b00, 2'b00, 1, 1));
      tick();
      tick();
      chk("to_w6", ev(5'b11111, 0, 0, 2'b00, 2'b00, 1, 1));
      tick();
      mem_ready = 1;
      chk("to_sticky", ev(5'b00000, 0, 0, 2'b00, 2'b00, 1, 1));

      // reset in the middle of a memory stall
      dec(1, 0, 0, 0, 0, 10, 1, 0, 0);
      tick();                              // E=add10 W=lw9
      dec(1, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();                              // E=sw M=add10
      dec_valid = 0;
      tick();                              // M=sw W=add10
      mem_ready = 0; ex_rs1 = 10;
      chk("pre_reset", ev(5'b11111, 0, 0, 2'b01, 2'b00, 1, 1));
      #3;
      rst = 1'b0;
      chk("async_reset", '0);
      tick();
      #3;
      rst = 1'b1;
      chk("after_release", '0);
      tick();
      chk("idle_after_release", '0);
      dec(1, 0, 0, 0, 0, 10, 1, 0, 0);
      tick();                              // E=add10
      dec_valid = 0;
      tick();                              // M=add10
      chk("new_fwd", ev(5'b00000, 0, 0, 2'b10, 2'b00, 0, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
